npc_ras_unit: RTL and testbench
===============================

Name: npc_ras_unit

Overview:
Parametrised successor to the combinational next-PC selector. It owns the fetch PC register and computes next-PC for sequential, branch, jump and jr flow. It also tracks branch delay slots in a register, captures EPC on exceptions and vectors to the handler, and keeps a return-address stack (RAS) that checks every jr return against its predicted target. It sits between the IF-stage PC register position and the ID-stage control and branch-compare logic.

Parameters:
XLEN, 32, PC/data width in bits (>= 32; jump-target concatenation uses bits [31:0], upper bits from pc).
RESET_PC, 32'h00003000, PC value loaded on reset.
EXC_VECTOR, 32'h00004180, exception handler entry PC.
RAS_DEPTH, 8, RAS entries (power of two, >= 2).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  advance enable; 0 = stall, hold all state
pc_src  input  2  0 seq, 1 branch, 2 jump, 3 jr; refers to the instruction at pc
b_pc  input  XLEN  branch target
instr_addr  input  26  jump index field
ra  input  XLEN  register value for jr
is_call  input  1  instruction at pc is jal/jalr
is_ret  input  1  instruction at pc is jr $31
exc_req  input  1  take exception this cycle
eret  input  1  return from exception this cycle
pc  output  XLEN  current fetch PC (registered)
pc_plus4  output  XLEN  pc + 4 (combinational)
next_pc  output  XLEN  value pc loads at next enabled edge (combinational)
in_delay_slot  output  1  instruction at pc is a delay-slot instruction (registered)
epc  output  XLEN  captured exception PC (registered)
ras_top  output  XLEN  current RAS top entry (combinational read)
ras_valid  output  1  RAS count != 0
ret_mispredict  output  1  one-cycle pulse (registered): last accepted return had ra != ras_top or RAS empty

Behaviour:
- Reset (async): pc=RESET_PC, in_delay_slot=0, epc=0, ras_valid=0 (count=0, ptr=0), ret_mispredict=0; RAS contents don't-care.
- next_pc priority: exc_req -> EXC_VECTOR; else eret -> epc; else pc_src 1 -> b_pc; 2 -> {pc[XLEN-1:28], instr_addr, 2'b00}; 3 -> ra; 0 -> pc+4. pc+4 wraps modulo 2^XLEN.
- Update condition: edge with (en | exc_req). exc_req overrides stall; eret and pc_src honoured only when en=1.
- On update: pc <= next_pc.
- in_delay_slot <= (pc_src != 0) & !exc_req & !eret.
- Exception: epc <= in_delay_slot ? pc-4 : pc; in_delay_slot <= 0; RAS unchanged; ret_mispredict <= 0.
- eret: in_delay_slot <= 0; epc unchanged.
- RAS operations occur only on a non-exception, non-eret update:
  - push when is_call; pushed value = pc+8 (skips delay slot).
  - pop when is_ret & pc_src==3.
- Overflow: push with count==RAS_DEPTH overwrites the oldest entry (circular pointer). Count saturates at RAS_DEPTH.
- Underflow: pop with count==0 leaves count=0 and ptr unchanged.
- Push and pop in the same update: top entry is replaced with the new value; count unchanged; if empty, behaves as a push.
- ret_mispredict <= pop & (!ras_valid | ra != ras_top), evaluated before the pop. It is 0 on every other update and holds its value while stalled.
- Pointer wrap: ptr increments and decrements modulo RAS_DEPTH.
- Reset mid-stall or mid-exception: reset dominates immediately, with no pending state retained.

Test Plan:
- Reset, then en=1 with pc_src=0 for 3 edges -> pc 0x3000, 0x3004, 0x3008, 0x300C; in_delay_slot=0 throughout.
- At pc=0x3010, pc_src=2, instr_addr=0x0000C40 -> next pc=0x00003100, in_delay_slot=1. The following seq edge -> pc=0x3104, in_delay_slot=0.
- At pc=0x3020: is_call with pc_src=2 pushes 0x3028. Later at another pc: is_ret, pc_src=3, ra=0x3028 -> pc=0x3028, ret_mispredict=0, ras_valid=0. Repeat with ra=0x3030 -> ret_mispredict=1 for one cycle.
- 9 pushes into RAS_DEPTH=8 (values A0..A8), then 8 pops with matching ra -> pops return A8..A1, no mispredict. A 9th pop on empty -> ret_mispredict=1, ras_valid=0.
- In delay slot at pc=0x3104, exc_req=1 while en=0 -> pc=0x4180, epc=0x3100. Then eret with en=1 -> pc=0x3100, in_delay_slot=0.
- Assert reset while en=0 at pc=0x3200 with 3 RAS entries -> pc=0x3000 and ras_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/npc_ras_unit.sv
// Fetch PC register with next-PC selection, delay-slot tracking, EPC capture
// and a circular return-address stack that checks jr returns.
module npc_ras_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h00003000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h00004180,
    parameter int              RAS_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] b_pc,
    input  logic [25:0]     instr_addr,
    input  logic [XLEN-1:0] ra,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic            exc_req,
    input  logic            eret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            in_delay_slot,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid,
    output logic            ret_mispredict
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0] EIGHT = XLEN'(8);
    localparam logic [CW-1:0]   FULL  = CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_in_ds;
    logic            r_mis;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus8;
    logic [XLEN-1:0] w_jump;
    logic [XLEN-1:0] w_next;
    logic [PW-1:0]   w_top_idx;
    logic            w_valid;
    logic            w_upd;
    logic            w_norm;
    logic            w_push;
    logic            w_pop;
    logic            w_mis;

    assign w_pc_plus4 = r_pc + FOUR;
    assign w_pc_plus8 = r_pc + EIGHT;
    assign w_jump     = {r_pc[XLEN-1:28], instr_addr, 2'b00};
    assign w_top_idx  = r_ptr - PW'(1);
    assign w_valid    = (r_cnt != '0);

    always_comb begin
        w_next = w_pc_plus4;
        if (exc_req) begin
            w_next = EXC_VECTOR;
        end else if (eret) begin
            w_next = r_epc;
        end else begin
            unique case (pc_src)
                2'd1:    w_next = b_pc;
                2'd2:    w_next = w_jump;
                2'd3:    w_next = ra;
                default: w_next = w_pc_plus4;
            endcase
        end
    end

    // Exceptions advance even while stalled; everything else needs en.
    assign w_upd  = en | exc_req;
    assign w_norm = en & ~exc_req & ~eret;
    assign w_push = w_norm & is_call;
    assign w_pop  = w_norm & is_ret & (pc_src == 2'd3);
    assign w_mis  = w_pop & (~w_valid | (ra != r_ras[w_top_idx]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_in_ds <= 1'b0;
            r_mis   <= 1'b0;
        end else if (w_upd) begin
            r_pc <= w_next;
            if (exc_req) begin
                r_epc   <= r_in_ds ? (r_pc - FOUR) : r_pc;
                r_in_ds <= 1'b0;
                r_mis   <= 1'b0;
            end else begin
                r_in_ds <= (pc_src != 2'd0) & ~eret;
                r_mis   <= w_mis;
            end
        end
    end

    // Push+pop on a non-empty stack replaces the top in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_push && !(w_pop && w_valid)) begin
            r_ptr <= r_ptr + PW'(1);
            r_cnt <= (r_cnt == FULL) ? r_cnt : r_cnt + CW'(1);
        end else if (w_pop && !w_push && w_valid) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            if (w_pop && w_valid) begin
                r_ras[w_top_idx] <= w_pc_plus8;
            end else begin
                r_ras[r_ptr] <= w_pc_plus8;
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign next_pc        = w_next;
    assign in_delay_slot  = r_in_ds;
    assign epc            = r_epc;
    assign ras_top        = r_ras[w_top_idx];
    assign ras_valid      = w_valid;
    assign ret_mispredict = r_mis;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed bench for npc_ras_unit: sequential/jump/branch flow, RAS push/pop,
// overflow and underflow, exception/eret and asynchronous reset.
module tb_npc_ras_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  pc_src;
    logic [31:0] b_pc;
    logic [25:0] instr_addr;
    logic [31:0] ra;
    logic        is_call;
    logic        is_ret;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        in_delay_slot;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic        ras_valid;
    logic        ret_mispredict;

    int checks;
    int failures;

    npc_ras_unit dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .pc_src         (pc_src),
        .b_pc           (b_pc),
        .instr_addr     (instr_addr),
        .ra             (ra),
        .is_call        (is_call),
        .is_ret         (is_ret),
        .exc_req        (exc_req),
        .eret           (eret),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .in_delay_slot  (in_delay_slot),
        .epc            (epc),
        .ras_top        (ras_top),
        .ras_valid      (ras_valid),
        .ret_mispredict (ret_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        en = 1'b0;
        pc_src = 2'd0;
        b_pc = '0;
        instr_addr = '0;
        ra = '0;
        is_call = 1'b0;
        is_ret = 1'b0;
        exc_req = 1'b0;
        eret = 1'b0;
        #3;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_ds", {31'd0, in_delay_slot}, 32'd0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_valid", {31'd0, ras_valid}, 32'd0);
        chk("rst_mis", {31'd0, ret_mispredict}, 32'd0);
        chk("rst_plus4", pc_plus4, 32'h3004);

        @(negedge clk);
        reset = 1'b0;
        en = 1'b1;
        step(); chk("seq1", pc, 32'h3004);
        chk("seq1_ds", {31'd0, in_delay_slot}, 32'd0);
        step(); chk("seq2", pc, 32'h3008);
        step(); chk("seq3", pc, 32'h300C);
        chk("seq3_ds", {31'd0, in_delay_slot}, 32'd0);
        step(); chk("seq4", pc, 32'h3010);

        pc_src = 2'd2;
        instr_addr = 26'hC40;
        #1 chk("jmp_npc", next_pc, 32'h3100);
        step(); chk("jmp_pc", pc, 32'h3100);
        chk("jmp_ds", {31'd0, in_delay_slot}, 32'd1);
        pc_src = 2'd0;
        step(); chk("ds_pc", pc, 32'h3104);
        chk("ds_clr", {31'd0, in_delay_slot}, 32'd0);

        pc_src = 2'd1;
        b_pc = 32'h3020;
        step(); chk("br_pc", pc, 32'h3020);
        pc_src = 2'd2;
        instr_addr = 26'hC20;
        is_call = 1'b1;
        step(); chk("call_pc", pc, 32'h3080);
        chk("call_valid", {31'd0, ras_valid}, 32'd1);
        chk("call_top", ras_top, 32'h3028);
        is_call = 1'b0;
        pc_src = 2'd0;
        step(); chk("call_ds", pc, 32'h3084);
        pc_src = 2'd3;
        is_ret = 1'b1;
        ra = 32'h3028;
        step(); chk("ret_pc", pc, 32'h3028);
        chk("ret_mis", {31'd0, ret_mispredict}, 32'd0);
        chk("ret_valid", {31'd0, ras_valid}, 32'd0);

        is_ret = 1'b0;
        pc_src = 2'd2;
        instr_addr = 26'hC08;
        step(); chk("jmp2_pc", pc, 32'h3020);
        is_call = 1'b1;
        instr_addr = 26'hC20;
        step(); chk("call2_top", ras_top, 32'h3028);
        is_call = 1'b0;
        pc_src = 2'd3;
        is_ret = 1'b1;
        ra = 32'h3030;
        step(); chk("bad_pc", pc, 32'h3030);
        chk("bad_mis", {31'd0, ret_mispredict}, 32'd1);
        chk("bad_valid", {31'd0, ras_valid}, 32'd0);
        is_ret = 1'b0;
        pc_src = 2'd0;
        en = 1'b0;
        step(); chk("stall_mis", {31'd0, ret_mispredict}, 32'd1);
        chk("stall_pc", pc, 32'h3030);
        en = 1'b1;
        step(); chk("mis_clr", {31'd0, ret_mispredict}, 32'd0);
        chk("mis_clr_pc", pc, 32'h3034);

        // nine pushes at 0x3034.. push 0x303C..0x305C
        is_call = 1'b1;
        for (int i = 0; i < 9; i++) step();
        is_call = 1'b0;
        chk("ovf_pc", pc, 32'h3058);
        chk("ovf_top", ras_top, 32'h305C);
        pc_src = 2'd3;
        is_ret = 1'b1;
        for (int j = 0; j < 8; j++) begin
            a = 32'h305C - 32'(4 * j);
            ra = a;
            #1 chk("pop_top", ras_top, a);
            step();
            chk("pop_mis", {31'd0, ret_mispredict}, 32'd0);
        end
        chk("pop_empty", {31'd0, ras_valid}, 32'd0);
        ra = 32'h3100;
        step(); chk("unf_mis", {31'd0, ret_mispredict}, 32'd1);
        chk("unf_valid", {31'd0, ras_valid}, 32'd0);
        chk("unf_pc", pc, 32'h3100);

        is_ret = 1'b0;
        pc_src = 2'd1;
        b_pc = 32'h3104;
        step(); chk("br3_ds", {31'd0, in_delay_slot}, 32'd1);
        chk("br3_mis", {31'd0, ret_mispredict}, 32'd0);
        pc_src = 2'd0;
        en = 1'b0;
        exc_req = 1'b1;
        #1 chk("exc_npc", next_pc, 32'h4180);
        step(); chk("exc_pc", pc, 32'h4180);
        chk("exc_epc", epc, 32'h3100);
        chk("exc_ds", {31'd0, in_delay_slot}, 32'd0);
        exc_req = 1'b0;
        en = 1'b1;
        eret = 1'b1;
        pc_src = 2'd1;
        b_pc = 32'h5555_0000;
        #1 chk("eret_npc", next_pc, 32'h3100);
        step(); chk("eret_pc", pc, 32'h3100);
        chk("eret_ds", {31'd0, in_delay_slot}, 32'd0);
        chk("eret_epc", epc, 32'h3100);

        eret = 1'b0;
        pc_src = 2'd0;
        is_call = 1'b1;
        step(); step(); step();
        chk("p3_top", ras_top, 32'h3110);
        is_call = 1'b0;
        pc_src = 2'd1;
        b_pc = 32'h3200;
        step(); chk("p3_pc", pc, 32'h3200);
        chk("p3_valid", {31'd0, ras_valid}, 32'd1);
        pc_src = 2'd0;
        en = 1'b0;
        step(); chk("p3_stall", pc, 32'h3200);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h3000);
        chk("arst_valid", {31'd0, ras_valid}, 32'd0);
        chk("arst_epc", epc, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        en = 1'b1;
        pc_src = 2'd3;
        ra = 32'hFFFF_FFFC;
        step(); chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        pc_src = 2'd0;
        #1 chk("wrap_npc", next_pc, 32'h0);
        pc_src = 2'd2;
        instr_addr = 26'h0;
        #1 chk("jhi_npc", next_pc, 32'hF000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
